// File: rtl/accel_seq_pkg.sv
// accel_seq_pkg: shared types for the accelerator slave sequencer.
// Holds the FSM state enum, host status codes and a select-width helper.
package accel_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_READ = 3'd3,
    S_ERR  = 3'd4
  } seq_state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD_SLV = 2'd2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accel_seq_fifo.sv
// accel_seq_fifo: synchronous config-word FIFO with flush.
// Ports: clk/rst_n, push+wdata, pop -> rdata (show-ahead), flush, full/empty/count.
module accel_seq_fifo
  import accel_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/accel_slave_sequencer.sv
// accel_slave_sequencer: buffers host config words, loads them into one of
// NUM_SLV slaves, waits for done, then reads results back with next strobes.
// Ports: wb_clk_i/wb_rst_ni; host_w* push, host_start/host_slv, host_r* read,
// host_busy/host_status, trig_o (high in RUN); slv_* per-slave bus.
// Option: SEQ_TIMEOUT_EN enables a RUN watchdog of TIMEOUT_CYC cycles.
module accel_slave_sequencer
  import accel_seq_pkg::*;
#(
  parameter int NUM_SLV     = 2,
  parameter int DATA_W      = 32,
  parameter int LOAD_WORDS  = 8,
  parameter int RES_WORDS   = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 65535,
  localparam int SEL_W      = sel_width(NUM_SLV)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      host_wvalid,
  output logic                      host_wready,
  input  logic [DATA_W-1:0]         host_wdata,
  input  logic                      host_start,
  input  logic [SEL_W-1:0]          host_slv,
  output logic                      host_rvalid,
  input  logic                      host_rready,
  output logic [DATA_W-1:0]         host_rdata,
  output logic                      host_busy,
  output logic [1:0]                host_status,
  output logic                      trig_o,
  output logic [NUM_SLV-1:0]        slv_enable,
  output logic [NUM_SLV-1:0]        slv_load,
  output logic [NUM_SLV-1:0]        slv_next,
  output logic [DATA_W-1:0]         slv_data_out,
  input  logic [NUM_SLV*DATA_W-1:0] slv_data_in,
  input  logic [NUM_SLV-1:0]        slv_done
);

  localparam int LC_W  = $clog2(LOAD_WORDS + 1);
  localparam int RC_W  = $clog2(RES_WORDS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SW1   = SEL_W + 1;

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_nx;
  logic [1:0]        status_nx;
  logic [LC_W-1:0]   load_cnt;
  logic [RC_W-1:0]   res_cnt;
  logic [NUM_SLV-1:0] oh;
  logic [NUM_SLV-1:0] oh_nx;
  logic              done_sel;
  logic              slv_ok;
  logic              pop;
  logic              hs;
  logic              last_res;
  logic              flush;
  logic              tmo_hit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_cnt;

  accel_seq_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (host_wvalid),
    .wdata (host_wdata),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_cnt  = ^fifo_count;
  assign host_wready = ~fifo_full;
  assign slv_ok      = ({1'b0, host_slv} < SW1'(NUM_SLV));
  assign flush       = (state == S_ERR);

  assign pop = (state == S_LOAD) && !fifo_empty
            && (load_cnt != LC_W'(LOAD_WORDS));

  // The slave advances its result word on the edge that samples slv_next,
  // so the word on the bus is stale while a next strobe is out.
  assign host_rvalid = (state == S_READ) && (slv_next == '0);
  assign hs          = host_rvalid & host_rready;
  assign last_res    = hs && (res_cnt == RC_W'(RES_WORDS - 1));

  always_comb begin
    oh         = '0;
    oh_nx      = '0;
    host_rdata = '0;
    done_sel   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      oh[i]    = (sel == SEL_W'(i));
      oh_nx[i] = (sel_nx == SEL_W'(i));
      if (oh[i]) begin
        host_rdata = slv_data_in[i*DATA_W +: DATA_W];
        done_sel   = slv_done[i];
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)         tmo_cnt <= '0;
    else if (state != S_RUN) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TC_W'(1);
  end

  assign tmo_hit = (tmo_cnt == TC_W'(TIMEOUT_CYC));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    status_nx = host_status;
    unique case (state)
      S_IDLE: begin
        if (host_start) begin
          if (slv_ok) begin
            sel_nx   = host_slv;
            state_nx = S_LOAD;
          end else begin
            status_nx = ST_BAD_SLV;
          end
        end
      end
      S_LOAD: begin
        if (load_cnt == LC_W'(LOAD_WORDS))
          state_nx = S_RUN;
      end
      S_RUN: begin
        if (done_sel) begin
          state_nx = S_READ;
        end else if (tmo_hit) begin
          state_nx  = S_ERR;
          status_nx = ST_TIMEOUT;
        end
      end
      S_READ: begin
        if (last_res) begin
          state_nx  = S_IDLE;
          status_nx = ST_OK;
        end
      end
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      sel          <= '0;
      host_status  <= ST_OK;
      host_busy    <= 1'b0;
      trig_o       <= 1'b0;
      slv_enable   <= '0;
      slv_load     <= '0;
      slv_next     <= '0;
      slv_data_out <= '0;
      load_cnt     <= '0;
      res_cnt      <= '0;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      host_status <= status_nx;
      host_busy   <= (state_nx != S_IDLE);
      trig_o      <= (state_nx == S_RUN);
      slv_enable  <= (state_nx inside {S_LOAD, S_RUN, S_READ})
                   ? oh_nx : '0;
      slv_load    <= pop ? oh : '0;
      slv_next    <= hs ? oh : '0;
      if (pop) slv_data_out <= fifo_rdata;
      if (state == S_IDLE) load_cnt <= '0;
      else if (pop)        load_cnt <= load_cnt + LC_W'(1);
      if (state != S_READ) res_cnt <= '0;
      else if (hs)         res_cnt <= res_cnt + RC_W'(1);
    end
  end

endmodule
